// File: rtl/ps2_pkg.sv
// Shared widths, bit positions and the queued key-event payload for the
// hps_io keyboard path.
package ps2_pkg;

    localparam int unsigned KEY_W   = 11;
    localparam int unsigned ENTRY_W = 10;
    localparam int unsigned CODE_W  = 8;

    // Bit positions inside the hps_io key word
    localparam int unsigned TOG_BIT = 10;
    localparam int unsigned PRS_BIT = 9;
    localparam int unsigned EXT_BIT = 8;

    // One queued key event, packed as {pressed, extended, code}
    typedef struct packed {
        logic              pressed;
        logic              extended;
        logic [CODE_W-1:0] code;
    } key_evt_t;

endpackage

// File: rtl/sync_fifo.sv
// Plain single-clock FIFO. Push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; pop while empty is ignored. No overflow
// reporting here, the owner decides what a refused push means.
//   clk, reset : clock, synchronous active-high reset
//   push/wr_data, pop : write and read strobes
//   rd_data    : head entry, read combinationally from storage
//   count/full/empty : occupancy status, derived from count
module sync_fifo #(
    parameter  int unsigned WIDTH = 10,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle makes room, so a full FIFO still takes the push
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (!do_push && do_pop) count <= count - (AW+1)'(1);
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ps2_key_fifo.sv
// Turns the toggle-strobed hps_io key word into discrete key events and
// queues them for the CPU, with occupancy status and a sticky overflow flag.
//   clk_sys, reset : clock, synchronous active-high reset
//   ps2_key        : {toggle, pressed, extended, code[7:0]}
//   rd_pop         : consume head entry
//   clr_ovf        : clear sticky overflow
//   rd_data/rd_valid : head entry {pressed, extended, code} and not-empty
//   count/full     : occupancy 0..DEPTH, count==DEPTH
//   overflow       : sticky, an event was dropped on a full queue
module ps2_key_fifo
    import ps2_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [KEY_W-1:0]   ps2_key,
    input  logic               rd_pop,
    input  logic               clr_ovf,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic [AW:0]        count,
    output logic               full,
    output logic               overflow
);

    logic     last_tog;
    logic     evt;
    logic     pend;
    key_evt_t pend_evt;
    logic     empty;
    logic     drop;

    assign evt = (ps2_key[TOG_BIT] != last_tog);
    // Refused only when full and no pop frees a slot this cycle
    assign drop = pend && full && !rd_pop;
    assign rd_valid = !empty;

    // Tracking the toggle through reset avoids a spurious event afterwards
    always_ff @(posedge clk_sys) begin
        last_tog <= ps2_key[TOG_BIT];
    end

    // Pending push stage: one cycle between detection and FIFO write
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pend <= evt;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    // Payload captured on the detection cycle
    always_ff @(posedge clk_sys) begin
        if (evt) begin
            pend_evt.pressed  <= ps2_key[PRS_BIT];
            pend_evt.extended <= ps2_key[EXT_BIT];
            pend_evt.code     <= ps2_key[CODE_W-1:0];
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_sys),
        .reset   (reset),
        .push    (pend),
        .wr_data (pend_evt),
        .pop     (rd_pop),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

endmodule
